ssd_scan_driver: RTL and testbench

Time-multiplexed four-digit seven-segment scan driver that consumes the 20-bit symbol word (`ssd`, four 5-bit symbol codes) produced by the lock controller state machine. It drives the anode and segment pins of the board display. Per-digit 1 Hz blinking supports digit-entry prompts. A frame-synchronous shadow register prevents tearing when `ssd` changes mid-scan.

---
 rtl/ssd_scan_driver_if.sv | 11 +
 rtl/ssd_scan_driver.sv | 110 +++++++++++
 tb/tb_ssd_scan_driver.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ssd_scan_driver_if.sv
// Symbol/mask inputs and display pin outputs of the seven-segment scan driver.
interface ssd_scan_driver_if;
  logic [19:0] ssd;
  logic [3:0]  blink_mask;
  logic [3:0]  AN;
  logic [6:0]  seven_out;
  logic        frame_tick;

  modport master (output ssd, output blink_mask, input AN, input seven_out, input frame_tick);
  modport slave  (input ssd, input blink_mask, output AN, output seven_out, output frame_tick);
endinterface

// File: rtl/ssd_scan_driver.sv
// Four-digit time-multiplexed seven-segment driver with per-digit blink and a
// frame-synchronous shadow of the symbol word so mid-scan updates never tear.
module ssd_scan_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 500,
  parameter int BLINK_HALF  = 25000000
) (
  input logic              clk,
  input logic              rst,
  ssd_scan_driver_if.slave bus
);
  localparam int SW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] GUARD_C    = SW'(GUARD);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [19:0]   BLANK4     = 20'h9CE73;

  logic [SW-1:0]     r_slot_cnt;
  logic [1:0]        r_idx;
  logic [BW-1:0]     r_blink_cnt;
  logic              r_blink_phase;
  logic [19:0]       r_shadow_ssd;
  logic [3:0]        r_shadow_mask;
  logic [3:0]        r_an;
  logic [6:0]        r_seg;
  logic              r_frame_tick;

  logic [3:0][4:0]   w_syms;
  logic [4:0]        w_sym;
  logic [6:0]        w_dec;
  logic              w_frame_start;
  logic              w_slot_wrap;

  assign w_syms        = r_shadow_ssd;
  assign w_sym         = w_syms[r_idx];
  assign w_frame_start = (r_slot_cnt == '0) && (r_idx == 2'd3);
  assign w_slot_wrap   = (r_slot_cnt == SLOT_LAST);

  always_comb begin
    w_dec = 7'h7F;
    case (w_sym)
      5'd0:  w_dec = 7'h40;
      5'd1:  w_dec = 7'h79;
      5'd2:  w_dec = 7'h24;
      5'd3:  w_dec = 7'h30;
      5'd4:  w_dec = 7'h19;
      5'd5:  w_dec = 7'h12;
      5'd6:  w_dec = 7'h02;
      5'd7:  w_dec = 7'h78;
      5'd8:  w_dec = 7'h00;
      5'd9:  w_dec = 7'h10;
      5'd10: w_dec = 7'h46;
      5'd11: w_dec = 7'h47;
      5'd12: w_dec = 7'h12;
      5'd13: w_dec = 7'h21;
      5'd14: w_dec = 7'h40;
      5'd15: w_dec = 7'h0C;
      5'd16: w_dec = 7'h06;
      5'd17: w_dec = 7'h2B;
      5'd18: w_dec = 7'h3F;
      5'd20: w_dec = 7'h2F;
      default: w_dec = 7'h7F;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot_cnt    <= '0;
      r_idx         <= 2'd3;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_shadow_ssd  <= BLANK4;
      r_shadow_mask <= 4'h0;
      r_an          <= 4'hF;
      r_seg         <= 7'h7F;
      r_frame_tick  <= 1'b0;
    end else begin
      // Digit order 3,2,1,0 falls out of a plain 2-bit decrement.
      r_slot_cnt <= w_slot_wrap ? '0 : r_slot_cnt + 1'b1;
      if (w_slot_wrap) r_idx <= r_idx - 2'd1;

      r_frame_tick <= w_frame_start;
      if (w_frame_start) begin
        r_shadow_ssd  <= bus.ssd;
        r_shadow_mask <= bus.blink_mask;
      end

      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end

      // A blinked-off digit keeps its anode on; only the segments go dark.
      if (r_slot_cnt < GUARD_C) begin
        r_an  <= 4'hF;
        r_seg <= 7'h7F;
      end else begin
        r_an  <= ~(4'b0001 << r_idx);
        r_seg <= (r_shadow_mask[r_idx] && r_blink_phase) ? 7'h7F : w_dec;
      end
    end
  end

  assign bus.AN         = r_an;
  assign bus.seven_out  = r_seg;
  assign bus.frame_tick = r_frame_tick;
endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench: a cycle-indexed reference model queues the expected pins,
// a negedge monitor pops and compares them against the driver outputs.
module tb_ssd_scan_driver;
  localparam int RD = 8, GD = 2, BH = 64;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       tick;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  ssd_scan_driver_if bus();

  ssd_scan_driver #(.REFRESH_DIV(RD), .GUARD(GD), .BLINK_HALF(BH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [6:0] dec_tab [32];
  exp_t       sb_q [$];
  int         errors = 0;
  int         checks = 0;
  bit         done   = 0;

  initial begin
    for (int i = 0; i < 32; i++) dec_tab[i] = 7'h7F;
    dec_tab[0]  = 7'h40; dec_tab[1]  = 7'h79; dec_tab[2]  = 7'h24; dec_tab[3]  = 7'h30;
    dec_tab[4]  = 7'h19; dec_tab[5]  = 7'h12; dec_tab[6]  = 7'h02; dec_tab[7]  = 7'h78;
    dec_tab[8]  = 7'h00; dec_tab[9]  = 7'h10; dec_tab[10] = 7'h46; dec_tab[11] = 7'h47;
    dec_tab[12] = 7'h12; dec_tab[13] = 7'h21; dec_tab[14] = 7'h40; dec_tab[15] = 7'h0C;
    dec_tab[16] = 7'h06; dec_tab[17] = 7'h2B; dec_tab[18] = 7'h3F; dec_tab[20] = 7'h2F;
  end

  // Reference: after the k-th edge since reset release, everything follows
  // from k alone plus the word captured at the most recent 32-cycle frame start.
  int          k = 0;
  logic [19:0] m_ssd  = 20'h9CE73;
  logic [3:0]  m_mask = 4'h0;

  always @(posedge clk) begin
    exp_t e;
    int slot, idx, ph;
    logic [4:0] sym;
    if (rst) begin
      e = '{an: 4'hF, seg: 7'h7F, tick: 1'b0};
      k = 0;
      m_ssd = 20'h9CE73;
      m_mask = 4'h0;
    end else begin
      slot = k % RD;
      idx  = 3 - ((k / RD) % 4);
      ph   = (k / BH) % 2;
      sym  = m_ssd[idx*5 +: 5];
      e.tick = ((k % (4*RD)) == 0);
      if (slot < GD) begin
        e.an = 4'hF; e.seg = 7'h7F;
      end else begin
        e.an = 4'hF; e.an[idx] = 1'b0;
        e.seg = (m_mask[idx] && ph == 1) ? 7'h7F : dec_tab[sym];
      end
      if (e.tick) begin
        m_ssd = bus.ssd;
        m_mask = bus.blink_mask;
      end
      k++;
    end
    sb_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (!done && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (bus.AN !== e.an || bus.seven_out !== e.seg || bus.frame_tick !== e.tick) begin
        errors++;
        $display("FAIL pins t=%0t: got AN=%h seg=%h tick=%b, want AN=%h seg=%h tick=%b",
                 $time, bus.AN, bus.seven_out, bus.frame_tick, e.an, e.seg, e.tick);
      end
      checks++;
      if ($countones(~bus.AN) > 1) begin
        errors++;
        $display("FAIL one_anode t=%0t: got AN=%h, want at most one low bit", $time, bus.AN);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    bus.ssd = {5'd10, 5'd11, 5'd12, 5'd13};
    bus.blink_mask = 4'h0;
    cyc(3);
    rst = 1'b0;

    // Change lands inside the digit-2 slot of the first frame.
    cyc(11);
    bus.ssd = {5'd14, 5'd15, 5'd16, 5'd17};
    cyc(90);

    bus.ssd = {5'd7, 5'd1, 5'd2, 5'd3};
    bus.blink_mask = 4'b1000;
    cyc(300);

    bus.ssd = {5'd18, 5'd19, 5'd20, 5'd31};
    bus.blink_mask = 4'h0;
    cyc(70);

    for (int i = 0; i < 25; i++) begin
      bus.ssd = 20'($urandom);
      bus.blink_mask = 4'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        rst = 1'b1;
        cyc($urandom_range(1, 3));
        rst = 1'b0;
      end
      cyc($urandom_range(1, 60));
    end

    // Reset while digit 2 is lit, then confirm the scan restarts cleanly.
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (bus.AN == 4'hB) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_anB: got no AN=B within 100 cycles, want AN=B");
    end
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    bus.ssd = {5'd0, 5'd1, 5'd2, 5'd3};
    cyc(70);

    done = 1;
    checks++;
    if (sb_q.size() > 1) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, want at most 1", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
